match_search: RTL and testbench

Sequential search engine that feeds the 4-bit equality comparator. On a start request it latches a key, reads table entries in address order through a registered read port, and presents each `(entry, key)` pair to the comparator's `a`/`b` inputs. It samples the comparator's `status` output and reports the lowest matching address, or a miss. It sits between the datapath control FSM and a small lookup table in the mips8 datapath.

---
 rtl/match_search_pkg.sv | 13 +
 rtl/addr_counter.sv | 26 ++
 rtl/match_search.sv | 110 +++++++++++
 tb/tb_match_search.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/match_search_pkg.sv
// Shared definitions for the match_search engine: FSM encoding and default sizes.
package match_search_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addr_counter.sv
// Table address counter: clears to 0, increments on enable, saturates at N-1.
module addr_counter #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] count,
    output logic              last
);

    logic [ADDR_W-1:0] count_q;

    assign last  = (count_q == {ADDR_W{1'b1}});
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_q <= '0;
        end else if (en && !last) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/match_search.sv
// Sequential table search: issues reads in ascending address order and reports
// the lowest address whose entry equals the latched key, using an external comparator.
module match_search
    import match_search_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  key,
    output logic              ready,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [WIDTH-1:0]  tbl_data,
    output logic [WIDTH-1:0]  cmp_a,
    output logic [WIDTH-1:0]  cmp_b,
    input  logic              cmp_status,
    output logic              done,
    output logic              hit,
    output logic [ADDR_W-1:0] hit_addr
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  key_q, key_d;
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] hit_addr_q, hit_addr_d;
    logic [ADDR_W-1:0] tag_q;
    logic              cmp_vld_q;
    logic              issued_last_q, issued_last_d;
    logic              accept, issue_vld;
    logic [ADDR_W-1:0] count;
    logic              last;

    assign accept    = (state_q == S_IDLE) && start;
    // Once address N-1 has been issued the counter holds, so further cycles issue nothing.
    assign issue_vld = (state_q == S_SCAN) && !issued_last_q;

    addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (issue_vld),
        .count (count),
        .last  (last)
    );

    assign tbl_addr = count;
    assign cmp_a    = tbl_data;
    assign cmp_b    = key_q;
    assign ready    = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);
    assign hit      = hit_q;
    assign hit_addr = hit_addr_q;

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        hit_d         = hit_q;
        hit_addr_d    = hit_addr_q;
        issued_last_d = issued_last_q;
        if (issue_vld && last) issued_last_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d         = key;
                    hit_d         = 1'b0;
                    hit_addr_d    = '0;
                    issued_last_d = 1'b0;
                    state_d       = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cmp_vld_q) begin
                    if (cmp_status) begin
                        hit_d      = 1'b1;
                        hit_addr_d = tag_q;
                        state_d    = S_DONE;
                    end else if (tag_q == {ADDR_W{1'b1}}) begin
                        hit_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            key_q         <= '0;
            hit_q         <= 1'b0;
            hit_addr_q    <= '0;
            tag_q         <= '0;
            cmp_vld_q     <= 1'b0;
            issued_last_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            hit_q         <= hit_d;
            hit_addr_q    <= hit_addr_d;
            tag_q         <= count;
            cmp_vld_q     <= issue_vld;
            issued_last_q <= issued_last_d;
        end
    end

endmodule

// File: tb/tb_match_search.sv
// Bench for match_search with a registered-read table and an equality comparator.
module tb_match_search;

    localparam int W = 4;
    localparam int A = 3;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] key = '0;
    logic         ready;
    logic [A-1:0] tbl_addr;
    logic [W-1:0] tbl_data = '0;
    logic [W-1:0] cmp_a, cmp_b;
    logic         cmp_status;
    logic         done, hit;
    logic [A-1:0] hit_addr;
    logic [W-1:0] mem [N];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) tbl_data <= mem[tbl_addr];
    assign cmp_status = (cmp_a == cmp_b);

    match_search #(.WIDTH(W), .ADDR_W(A)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .ready      (ready),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .cmp_status (cmp_status),
        .done       (done),
        .hit        (hit),
        .hit_addr   (hit_addr)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_idx(input logic [W-1:0] k);
        for (int i = 0; i < N; i++) if (mem[i] == k) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; the accept edge ends the current cycle (cycle 0).
    task automatic run_search(input logic [W-1:0] k, input int busy_cyc, input logic [W-1:0] busy_key);
        int exp_idx, exp_cyc, cyc;
        bit got;
        exp_idx = model_idx(k);
        exp_cyc = (exp_idx >= 0) ? exp_idx + 3 : N + 2;
        check("ready_c0", int'(ready), 1);
        start = 1'b1;
        key   = k;
        tick();
        start = 1'b0;
        key   = W'($urandom);
        cyc   = 1;
        got   = 1'b0;
        check("tbl_addr_c1", int'(tbl_addr), 0);
        while (cyc < 20) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
            cyc++;
            if (cyc == busy_cyc) begin
                start = 1'b1;
                key   = busy_key;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen", int'(got), 1);
        check("done_cycle", cyc, exp_cyc);
        check("hit", int'(hit), (exp_idx >= 0) ? 1 : 0);
        check("hit_addr", int'(hit_addr), (exp_idx >= 0) ? exp_idx : 0);
        if (exp_idx < 0) check("tbl_addr_hold", int'(tbl_addr), N - 1);
        tick();
        check("done_pulse_end", int'(done), 0);
        check("ready_after_done", int'(ready), 1);
        check("hit_stable", int'(hit), (exp_idx >= 0) ? 1 : 0);
    endtask

    initial begin
        logic [W-1:0] tv [N];
        int pulses;
        tv = '{4'h3, 4'h9, 4'h5, 4'hA, 4'h5, 4'h0, 4'hF, 4'h1};
        for (int i = 0; i < N; i++) mem[i] = tv[i];

        // Reset defaults
        reset = 1'b1;
        tick();
        tick();
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_hit_addr", int'(hit_addr), 0);
        check("rst_tbl_addr", int'(tbl_addr), 0);
        reset = 1'b0;
        tick();

        // Directed searches on the fixed table
        run_search(4'h5, 0, 4'h0);
        run_search(4'h3, 0, 4'h0);
        run_search(4'h1, 0, 4'h0);
        run_search(4'h7, 0, 4'h0);
        // Start while busy is ignored, then back-to-back start after done
        run_search(4'h5, 2, 4'hF);
        run_search(4'hF, 0, 4'h0);

        // Start coinciding with reset: reset wins
        reset = 1'b1;
        start = 1'b1;
        key   = 4'h5;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_ready", int'(ready), 1);
        tick();
        check("rst_start_idle", int'(ready), 1);
        check("rst_start_no_done", int'(done), 0);

        // Reset mid-scan for key F
        start = 1'b1;
        key   = 4'hF;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_ready", int'(ready), 1);
        check("midrst_done", int'(done), 0);
        check("midrst_tbl_addr", int'(tbl_addr), 0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) pulses++;
            tick();
        end
        check("midrst_no_done", pulses, 0);
        run_search(4'hF, 0, 4'h0);

        // Randomized tables and keys against the model
        for (int t = 0; t < 25; t++) begin
            logic [W-1:0] k;
            for (int i = 0; i < N; i++) mem[i] = W'($urandom);
            k = (t % 3 == 0) ? W'($urandom) : mem[$urandom_range(N - 1, 0)];
            run_search(k, (t % 4 == 1) ? int'($urandom_range(4, 2)) : 0, W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
